// File: rtl/zx_keyboard.sv
// PS/2 set-2 receiver feeding an 8x5 ZX Spectrum key matrix, plus F12/F5 hold levels.
// Latency: raw PS/2 clock fall to accepted fall 2+FILTER cycles; matrix updates 2 cycles after the stop-bit fall.
// Backpressure: none; PS/2 is a push source and key_data is a combinational read of the matrix.
module zx_keyboard #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  input  logic [7:0] addr,
  output logic [4:0] key_data,
  output logic       key_reset,
  output logic       key_nmi,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  // Bit 0 carries the PS/2 clock, bit 1 the PS/2 data.
  logic [1:0]          s1_q, s2_q;
  logic [1:0]          filt_q, filt_d;
  logic [1:0][FW-1:0]  fcnt_q, fcnt_d;
  logic                fall_w, dat_w;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [7:0]          sh_q, sh_d;
  logic                par_q, par_d, stop_q, stop_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                timeout_w, frame_ok, frame_bad;

  logic                brk_q, brk_d, ext_q, ext_d;
  logic [39:0]         mat_q, mat_d, pressed_w;
  logic                ssr_q, ssr_d, ssl_q, ssl_d;
  logic                rst_q, rst_d, nmi_q, nmi_d, err_q;
  logic                map_hit;
  logic [5:0]          map_idx;

  // Two-flop synchronisers and stability filters; lines idle high.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= 2'b11;
      s2_q   <= 2'b11;
      filt_q <= 2'b11;
      fcnt_q <= '0;
    end else begin
      s1_q   <= {ps2_kbd_data, ps2_kbd_clk};
      s2_q   <= s1_q;
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  // A line must disagree with its filtered value for FILTER consecutive cycles before it is taken.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FW'(FILTER - 1)) filt_d[i] = s2_q[i];
        else fcnt_d[i] = fcnt_q[i] + 1'b1;
      end
    end
  end

  assign fall_w    = filt_q[0] & ~filt_d[0];
  assign dat_w     = filt_q[1];
  assign timeout_w = (tmo_q == TW'(TIMEOUT));

  // Receiver state register and frame datapath registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      tmo_q   <= tmo_d;
    end
  end

  // Receiver next state: start bit opens a frame, stop-bit fall closes it, silence abandons it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fall_w && !dat_w) state_d = SHIFT;
      SHIFT: begin
        if (fall_w) begin
          if (cnt_q == 4'd10) state_d = CHECK;
        end else if (timeout_w) begin
          state_d = IDLE;
        end
      end
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame datapath: bit counter, LSB-first shifter, parity/stop capture and inactivity counter.
  always_comb begin
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    par_d  = par_q;
    stop_d = stop_q;
    tmo_d  = '0;
    case (state_q)
      IDLE: if (fall_w && !dat_w) cnt_d = 4'd1;
      SHIFT: begin
        if (fall_w) begin
          cnt_d = (cnt_q == 4'd10) ? 4'd0 : cnt_q + 4'd1;
          if (cnt_q <= 4'd8)      sh_d   = {dat_w, sh_q[7:1]};
          else if (cnt_q == 4'd9) par_d  = dat_w;
          else                    stop_d = dat_w;
        end else if (timeout_w) begin
          cnt_d = 4'd0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: cnt_d = 4'd0;
    endcase
  end

  // Receiver outputs: frame verdict during CHECK (odd parity over data+parity, stop high).
  always_comb begin
    frame_ok  = (state_q == CHECK) && (^{par_q, sh_q}) && stop_q;
    frame_bad = (state_q == CHECK) && !frame_ok;
  end

  // Scan-code to matrix bit index (row*5 + column); SYMSHIFT sources are handled separately.
  always_comb begin
    map_hit = 1'b1;
    map_idx = 6'd0;
    case (sh_q)
      8'h12: map_idx = 6'd0;   8'h1A: map_idx = 6'd1;   8'h22: map_idx = 6'd2;
      8'h21: map_idx = 6'd3;   8'h2A: map_idx = 6'd4;
      8'h1C: map_idx = 6'd5;   8'h1B: map_idx = 6'd6;   8'h23: map_idx = 6'd7;
      8'h2B: map_idx = 6'd8;   8'h34: map_idx = 6'd9;
      8'h15: map_idx = 6'd10;  8'h1D: map_idx = 6'd11;  8'h24: map_idx = 6'd12;
      8'h2D: map_idx = 6'd13;  8'h2C: map_idx = 6'd14;
      8'h16: map_idx = 6'd15;  8'h1E: map_idx = 6'd16;  8'h26: map_idx = 6'd17;
      8'h25: map_idx = 6'd18;  8'h2E: map_idx = 6'd19;
      8'h45: map_idx = 6'd20;  8'h46: map_idx = 6'd21;  8'h3E: map_idx = 6'd22;
      8'h3D: map_idx = 6'd23;  8'h36: map_idx = 6'd24;
      8'h4D: map_idx = 6'd25;  8'h44: map_idx = 6'd26;  8'h43: map_idx = 6'd27;
      8'h3C: map_idx = 6'd28;  8'h35: map_idx = 6'd29;
      8'h5A: map_idx = 6'd30;  8'h4B: map_idx = 6'd31;  8'h42: map_idx = 6'd32;
      8'h3B: map_idx = 6'd33;  8'h33: map_idx = 6'd34;
      8'h29: map_idx = 6'd35;  8'h3A: map_idx = 6'd37;  8'h31: map_idx = 6'd38;
      8'h32: map_idx = 6'd39;
      default: map_hit = 1'b0;
    endcase
  end

  // Decoder: prefix flags, matrix and special-key levels; a rejected frame drops pending prefixes.
  always_comb begin
    brk_d = brk_q;
    ext_d = ext_q;
    mat_d = mat_q;
    ssr_d = ssr_q;
    ssl_d = ssl_q;
    rst_d = rst_q;
    nmi_d = nmi_q;
    if (frame_bad) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else if (frame_ok) begin
      if (sh_q == 8'hF0)      brk_d = 1'b1;
      else if (sh_q == 8'hE0) ext_d = 1'b1;
      else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (!ext_q) begin
          if (map_hit) mat_d[map_idx] = ~brk_q;
          case (sh_q)
            8'h59:   ssr_d = ~brk_q;
            8'h14:   ssl_d = ~brk_q;
            8'h07:   rst_d = ~brk_q;
            8'h03:   nmi_d = ~brk_q;
            default: ;
          endcase
        end
      end
    end
  end

  // Decoder state and the one-cycle error pulse following CHECK.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      brk_q <= 1'b0;
      ext_q <= 1'b0;
      mat_q <= '0;
      ssr_q <= 1'b0;
      ssl_q <= 1'b0;
      rst_q <= 1'b0;
      nmi_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      brk_q <= brk_d;
      ext_q <= ext_d;
      mat_q <= mat_d;
      ssr_q <= ssr_d;
      ssl_q <= ssl_d;
      rst_q <= rst_d;
      nmi_q <= nmi_d;
      err_q <= frame_bad;
    end
  end

  // Readout: active-low AND of every row whose address bit is low.
  always_comb begin
    pressed_w     = mat_q;
    pressed_w[36] = mat_q[36] | ssr_q | ssl_q;
    key_data      = 5'h1F;
    for (int r = 0; r < 8; r++) begin
      if (!addr[r]) key_data = key_data & ~pressed_w[r*5 +: 5];
    end
  end

  assign key_reset = rst_q;
  assign key_nmi   = nmi_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_zx_keyboard.sv
// Bench for zx_keyboard: PS/2 frames in, matrix readout/special keys/error pulses checked.
// Stimulus pushes expected readouts into a queue; a monitor pops, drives addr and compares.
// Frame errors are tallied per cycle so a stretched or missing pulse shows as a count mismatch.
module tb_zx_keyboard;

  localparam int H    = 20;
  localparam int TOUT = 300;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_kbd_clk = 1'b1;
  logic       ps2_kbd_data = 1'b1;
  logic [7:0] addr = 8'h00;
  logic [4:0] key_data;
  logic       key_reset, key_nmi, frame_err;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [4:0] kd;
    logic       rst;
    logic       nmi;
    int         errs;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   err_cycles = 0;
  int   exp_errs = 0;

  zx_keyboard #(.FILTER(8), .TIMEOUT(TOUT)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ps2_kbd_clk  (ps2_kbd_clk),
    .ps2_kbd_data (ps2_kbd_data),
    .addr         (addr),
    .key_data     (key_data),
    .key_reset    (key_reset),
    .key_nmi      (key_nmi),
    .frame_err    (frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  // Every high cycle of frame_err counts; one rejected frame must add exactly one.
  always @(negedge clk_sys) if (frame_err === 1'b1) err_cycles++;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the next expectation, selects its rows and compares all outputs.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_sys);
      if (q.size() > 0) begin
        e = q.pop_front();
        addr = e.a;
        #1;
        chk({e.name, ".key_data"}, {3'b000, key_data}, {3'b000, e.kd});
        chk({e.name, ".key_reset"}, {7'd0, key_reset}, {7'd0, e.rst});
        chk({e.name, ".key_nmi"}, {7'd0, key_nmi}, {7'd0, e.nmi});
        chk({e.name, ".frame_err_cycles"}, 8'(err_cycles), 8'(e.errs));
      end
    end
  end

  task automatic push_exp(input string nm, input logic [7:0] a, input logic [4:0] kd,
                          input logic r, input logic n);
    exp_t e;
    int   k;
    e = '{nm, a, kd, r, n, exp_errs};
    q.push_back(e);
    k = 0;
    while (q.size() > 0 && k < 100) begin
      @(posedge clk_sys);
      k++;
    end
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL monitor_drain: %0d entries left, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Sends the first nbits of a frame: start, data LSB first, parity, stop.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop, input int nbits);
    logic [10:0] fr;
    fr = {stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_kbd_data = fr[i];
      idle(H);
      ps2_kbd_clk = 1'b0;
      idle(H);
      ps2_kbd_clk = 1'b1;
    end
    ps2_kbd_data = 1'b1;
    idle(3 * H);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, 11);
  endtask

  initial begin
    idle(5);
    push_exp("reset_state", 8'h00, 5'h1F, 1'b0, 1'b0);
    reset_n = 1'b1;
    idle(5);

    // Mid-frame reset clears a held key and the half-received frame.
    send(8'h1C);                         push_exp("make_A", 8'hFD, 5'h1E, 0, 0);
    send_frame(8'h1C, 1'b0, 1'b1, 5);
    reset_n = 1'b0;
    idle(3);
    push_exp("mid_frame_reset", 8'hFD, 5'h1F, 0, 0);
    reset_n = 1'b1;
    idle(5);
    send(8'h1C);                         push_exp("after_reset_A", 8'hFD, 5'h1E, 0, 0);
    send(8'hF0); send(8'h1C);            push_exp("break_A", 8'hFD, 5'h1F, 0, 0);

    // Make/break, multi-row selection, repeated make, stray break, unmapped code.
    send(8'h15);                         push_exp("make_Q", 8'hFB, 5'h1E, 0, 0);
                                         push_exp("Q_all_rows", 8'h00, 5'h1E, 0, 0);
    send(8'h1A);                         push_exp("make_Z", 8'hFE, 5'h1D, 0, 0);
                                         push_exp("QZ_all_rows", 8'h00, 5'h1C, 0, 0);
                                         push_exp("QZ_two_rows", 8'hFA, 5'h1C, 0, 0);
    send(8'h15);                         push_exp("repeat_make_Q", 8'hFB, 5'h1E, 0, 0);
    send(8'hF0); send(8'h15);            push_exp("break_Q", 8'hFB, 5'h1F, 0, 0);
                                         push_exp("Z_still_held", 8'hFE, 5'h1D, 0, 0);
    send(8'hF0); send(8'h1A);            push_exp("break_Z", 8'h00, 5'h1F, 0, 0);
    send(8'hF0); send(8'h33);            push_exp("stray_break_H", 8'h00, 5'h1F, 0, 0);
    send(8'hAA); send(8'hFE);            push_exp("unmapped", 8'h00, 5'h1F, 0, 0);

    // Symbol shift from two sources.
    send(8'h59);                         push_exp("ss_rshift", 8'h7F, 5'h1D, 0, 0);
    send(8'h14);                         push_exp("ss_both", 8'h7F, 5'h1D, 0, 0);
    send(8'hF0); send(8'h59);            push_exp("ss_lctrl_only", 8'h7F, 5'h1D, 0, 0);
    send(8'hF0); send(8'h14);            push_exp("ss_none", 8'h7F, 5'h1F, 0, 0);

    // Extended prefix and special keys.
    send(8'hE0); send(8'h12);            push_exp("ext_12_ignored", 8'hFE, 5'h1F, 0, 0);
    send(8'h07);                         push_exp("f12_make", 8'h00, 5'h1F, 1, 0);
    send(8'hF0); send(8'h07);            push_exp("f12_break", 8'h00, 5'h1F, 0, 0);
    send(8'hE0); send(8'h07);            push_exp("ext_f12_ignored", 8'h00, 5'h1F, 0, 0);
    send(8'h12);                         push_exp("ext_cleared_caps", 8'hFE, 5'h1E, 0, 0);
    send(8'hF0); send(8'h12);            push_exp("caps_break", 8'hFE, 5'h1F, 0, 0);
    send(8'h03);                         push_exp("f5_make", 8'h00, 5'h1F, 0, 1);
    send(8'hE0); send(8'hF0); send(8'h03); push_exp("ext_brk_f5_ignored", 8'h00, 5'h1F, 0, 1);
    send(8'hF0); send(8'h03);            push_exp("f5_break", 8'h00, 5'h1F, 0, 0);

    // Rejected frames: bad parity, bad stop, and a rejected frame dropping a pending break.
    send_frame(8'h15, 1'b1, 1'b1, 11);   exp_errs++;
                                         push_exp("bad_parity", 8'hFB, 5'h1F, 0, 0);
    send_frame(8'h15, 1'b0, 1'b0, 11);   exp_errs++;
                                         push_exp("bad_stop", 8'hFB, 5'h1F, 0, 0);
    send(8'hF0);
    send_frame(8'h33, 1'b1, 1'b1, 11);   exp_errs++;
    send(8'h1C);                         push_exp("err_clears_brk", 8'hFD, 5'h1E, 0, 0);
    send(8'hF0); send(8'h1C);            push_exp("break_A_again", 8'hFD, 5'h1F, 0, 0);

    // Truncated frame abandoned by the inactivity timeout.
    send_frame(8'h29, 1'b0, 1'b1, 5);
    idle(TOUT + 50);
    send(8'h29);                         push_exp("after_timeout_space", 8'h7F, 5'h1E, 0, 0);
    send(8'hF0); send(8'h29);            push_exp("break_space", 8'h7F, 5'h1F, 0, 0);

    // Short low glitch on the clock with data low must not start a frame.
    ps2_kbd_data = 1'b0;
    idle(H);
    ps2_kbd_clk = 1'b0;
    idle(3);
    ps2_kbd_clk = 1'b1;
    idle(H);
    ps2_kbd_data = 1'b1;
    idle(H);
                                         push_exp("glitch_no_effect", 8'h00, 5'h1F, 0, 0);
    send(8'h1A);                         push_exp("after_glitch_Z", 8'hFE, 5'h1D, 0, 0);
    send(8'hF0); send(8'h1A);            push_exp("after_glitch_break", 8'hFE, 5'h1F, 0, 0);

    idle(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
